// File: rtl/riscv_pipe2_datapath.sv
// Two-stage (fetch / execute) RV32I datapath with req/gnt instruction and data memory ports.
// Control signals come from an external decoder that looks at inst_out (the execute-stage instruction).
module riscv_pipe2_datapath #(
  parameter int              XLEN     = 32,
  parameter int              PC_W     = 15,
  parameter int              DADDR_W  = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pcsel_in,
  input  logic [2:0]         immsel_in,
  input  logic               regwen_in,
  input  logic               brun_in,
  input  logic               asel_in,
  input  logic               bsel_in,
  input  logic [3:0]         alusel_in,
  input  logic               memrw_in,
  input  logic [1:0]         wbsel_in,
  output logic [31:0]        inst_out,
  output logic               breq_out,
  output logic               brlt_out,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic               dmem_gnt,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               retire_out,
  output logic [PC_W-1:0]    retire_pc_out
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic [PC_W-1:0] pc_f_q, ex_pc_q, retire_pc_q;
  logic [31:0]     ex_inst_q;
  logic            ex_valid_q, retire_q;
  logic [XLEN-1:0] rf_q [32];

  logic [4:0]      rs1_idx, rs2_idx, rd_idx, shamt;
  logic [XLEN-1:0] rs1_val, rs2_val, imm, op_a, op_b, alu_result, wb_data;
  logic [XLEN-1:0] ex_pc_x, ex_pc4_x;
  logic [31:0]     imm32;
  logic            is_mem, ex_done, ex_free, redirect, fetch_accept;

  assign rs1_idx = ex_inst_q[19:15];
  assign rs2_idx = ex_inst_q[24:20];
  assign rd_idx  = ex_inst_q[11:7];
  assign rs1_val = (rs1_idx == 5'd0) ? '0 : rf_q[rs1_idx];
  assign rs2_val = (rs2_idx == 5'd0) ? '0 : rf_q[rs2_idx];

  assign inst_out  = ex_valid_q ? ex_inst_q : NOP_INST;
  assign imem_addr = pc_f_q;

  always_comb begin
    imm32 = '0;
    case (immsel_in)
      3'd0: imm32 = {{20{ex_inst_q[31]}}, ex_inst_q[31:20]};
      3'd1: imm32 = {{20{ex_inst_q[31]}}, ex_inst_q[31:25], ex_inst_q[11:7]};
      3'd2: imm32 = {{19{ex_inst_q[31]}}, ex_inst_q[31], ex_inst_q[7], ex_inst_q[30:25],
                     ex_inst_q[11:8], 1'b0};
      3'd3: imm32 = {ex_inst_q[31:12], 12'b0};
      3'd4: imm32 = {{11{ex_inst_q[31]}}, ex_inst_q[31], ex_inst_q[19:12], ex_inst_q[20],
                     ex_inst_q[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm      = XLEN'($signed(imm32));
  assign ex_pc_x  = XLEN'(ex_pc_q);
  assign ex_pc4_x = XLEN'(ex_pc_q + PC_W'(4));

  assign breq_out = (rs1_val == rs2_val);
  assign brlt_out = brun_in ? (rs1_val < rs2_val) : ($signed(rs1_val) < $signed(rs2_val));

  assign op_a  = asel_in ? ex_pc_x : rs1_val;
  assign op_b  = bsel_in ? imm : rs2_val;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_result = '0;
    case (alusel_in)
      4'd0:    alu_result = op_a + op_b;
      4'd1:    alu_result = op_a - op_b;
      4'd2:    alu_result = op_a << shamt;
      4'd3:    alu_result = XLEN'($signed(op_a) < $signed(op_b));
      4'd4:    alu_result = XLEN'(op_a < op_b);
      4'd5:    alu_result = op_a ^ op_b;
      4'd6:    alu_result = op_a >> shamt;
      4'd7:    alu_result = XLEN'($signed(op_a) >>> shamt);
      4'd8:    alu_result = op_a | op_b;
      4'd9:    alu_result = op_a & op_b;
      4'd10:   alu_result = op_b;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    wb_data = '0;
    case (wbsel_in)
      2'd0:    wb_data = dmem_rdata;
      2'd1:    wb_data = alu_result;
      2'd2:    wb_data = ex_pc4_x;
      default: wb_data = '0;
    endcase
  end

  // Handshake: a request is held with stable address/data until gnt is seen high in the
  // same cycle; that cycle completes the transfer (read data is valid alongside gnt).
  assign is_mem       = ex_valid_q & (memrw_in | (wbsel_in == 2'd0));
  assign ex_done      = ex_valid_q & (!is_mem | dmem_gnt);
  assign ex_free      = !ex_valid_q | ex_done;
  assign redirect     = ex_done & pcsel_in;
  assign fetch_accept = imem_gnt & ex_free & !redirect;

  assign imem_req      = !reset;
  assign dmem_req      = is_mem & !reset;
  assign dmem_we       = memrw_in;
  assign dmem_addr     = alu_result[DADDR_W-1:0];
  assign dmem_wdata    = rs2_val;
  assign retire_out    = retire_q & !reset;
  assign retire_pc_out = retire_pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q      <= RESET_PC;
      ex_valid_q  <= 1'b0;
      ex_inst_q   <= NOP_INST;
      ex_pc_q     <= '0;
      retire_q    <= 1'b0;
      retire_pc_q <= '0;
    end else begin
      retire_q <= ex_done;
      if (ex_done) retire_pc_q <= ex_pc_q;
      if (redirect) begin
        pc_f_q     <= {alu_result[PC_W-1:1], 1'b0};
        ex_valid_q <= 1'b0;
      end else if (fetch_accept) begin
        ex_inst_q  <= imem_rdata;
        ex_pc_q    <= pc_f_q;
        ex_valid_q <= 1'b1;
        pc_f_q     <= pc_f_q + PC_W'(4);
      end else if (ex_done) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (ex_done && regwen_in && (rd_idx != 5'd0)) begin
      rf_q[rd_idx] <= wb_data;
    end
  end

endmodule
